// File: rtl/exec_alu_stage.sv
// exec_alu_stage: registered ARM execute stage.
// Performs the data-processing operation on src_a and the shifted operand,
// evaluates the condition field against the local NZCV register and holds
// the result in an output register with a valid/ready handshake.
// Optional feature: define ALU_SHIFT_CARRY_EN to let flag-setting logical
// ops load C from the shifter carry-out; otherwise they leave C unchanged.
module exec_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [2:0]       alu_ctrl,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             shift_carry,
    input  logic [3:0]       rd,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       out_rd,
    output logic             out_reg_write,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       out_rd_q, out_rd_d;
    logic             out_reg_write_q, out_reg_write_d;
    logic [3:0]       flags_q, flags_d;

    logic             accept;
    logic             pass;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] alu_res;
    logic             c_new;
    logic             v_new;

    wire flag_n = flags_q[3];
    wire flag_z = flags_q[2];
    wire flag_c = flags_q[1];
    wire flag_v = flags_q[0];

    // The stage frees up as soon as the held result is being taken downstream.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifndef ALU_SHIFT_CARRY_EN
    logic unused_shift_carry;
    assign unused_shift_carry = shift_carry;
`endif

    // Condition check against the flags currently in the register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        pass = 1'b0;
        case (cond)
            4'b0000: pass = flag_z;                              // EQ
            4'b0001: pass = !flag_z;                             // NE
            4'b0010: pass = flag_c;                              // CS
            4'b0011: pass = !flag_c;                             // CC
            4'b0100: pass = flag_n;                              // MI
            4'b0101: pass = !flag_n;                             // PL
            4'b0110: pass = flag_v;                              // VS
            4'b0111: pass = !flag_v;                             // VC
            4'b1000: pass = flag_c && !flag_z;                   // HI
            4'b1001: pass = !flag_c || flag_z;                   // LS
            4'b1010: pass = (flag_n == flag_v);                  // GE
            4'b1011: pass = (flag_n != flag_v);                  // LT
            4'b1100: pass = !flag_z && (flag_n == flag_v);       // GT
            4'b1101: pass = flag_z || (flag_n != flag_v);        // LE
            4'b1110: pass = 1'b1;                                // AL
            default: pass = 1'b0;                                // never
        endcase
    end

    // ALU datapath; arithmetic is one bit wider to capture the carry-out.
    always_comb begin
        arith   = '0;
        alu_res = '0;
        c_new   = flag_c;
        v_new   = flag_v;
        case (alu_ctrl)
            3'b000: begin // ADD
                arith   = {1'b0, src_a} + {1'b0, src_b};
                alu_res = arith[MSB:0];
                c_new   = arith[WIDTH];
                v_new   = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
            end
            3'b001: begin // SUB: a - b, carry is NOT borrow
                arith   = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
                alu_res = arith[MSB:0];
                c_new   = arith[WIDTH];
                v_new   = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
            end
            3'b101: begin // RSB: b - a
                arith   = {1'b0, src_b} + {1'b0, ~src_a} + (WIDTH+1)'(1);
                alu_res = arith[MSB:0];
                c_new   = arith[WIDTH];
                v_new   = (src_b[MSB] != src_a[MSB]) && (alu_res[MSB] != src_b[MSB]);
            end
            default: begin // logical ops keep V
                case (alu_ctrl)
                    3'b010:  alu_res = src_a & src_b;   // AND
                    3'b011:  alu_res = src_a | src_b;   // ORR
                    3'b100:  alu_res = src_a ^ src_b;   // EOR
                    3'b110:  alu_res = src_b;           // MOV
                    default: alu_res = src_a & ~src_b;  // BIC
                endcase
`ifdef ALU_SHIFT_CARRY_EN
                c_new = shift_carry;
`endif
            end
        endcase
    end

    // Next-state selection for the output and flag registers.
    always_comb begin
        out_valid_d     = out_valid_q;
        result_d        = result_q;
        out_rd_d        = out_rd_q;
        out_reg_write_d = out_reg_write_q;
        flags_d         = flags_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            result_d        = alu_res;
            out_rd_d        = rd;
            out_reg_write_d = reg_write && pass;
            if (set_flags && pass) begin
                flags_d = {alu_res[MSB], (alu_res == '0), c_new, v_new};
            end
        end else if (out_ready) begin
            // Drain: nothing new arriving while the held result is taken.
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            out_rd_q        <= '0;
            out_reg_write_q <= 1'b0;
            flags_q         <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            result_q        <= result_d;
            out_rd_q        <= out_rd_d;
            out_reg_write_q <= out_reg_write_d;
            flags_q         <= flags_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_reg_write_q;
    assign flags         = flags_q;

endmodule
